// File: rtl/operand_seq3_pkg.sv
// Shared definitions for the three-operand adder feeder: operand width and sequencer states.
package operand_seq3_pkg;

    localparam int SEQ_W = 4;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_B   = 3'd1,
        S_C   = 3'd2,
        S_SUM = 3'd3,
        S_OUT = 3'd4
    } state_t;

endpackage

// File: rtl/operand_seq3.sv
// Collects three operands from a valid/ready stream, feeds an external 4-bit three-operand adder,
// and presents the registered {cout,s} result on a valid/ready output stream.
module operand_seq3
    import operand_seq3_pkg::*;
#(
    parameter int W = SEQ_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] add_x,
    output logic [W-1:0] add_y,
    output logic [W-1:0] add_z,
    input  logic [W:0]   add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] out_data
);

    state_t state;
    state_t state_next;
    logic   accept;

    // Handshake outputs are forced low for the whole reset cycle, not only after the edge.
    always_comb begin
        in_ready  = rst_n && ((state == S_A) || (state == S_B) || (state == S_C));
        out_valid = rst_n && (state == S_OUT);
        accept    = in_valid && in_ready && !clr;
    end

    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = S_A;
        end else begin
            case (state)
                S_A:     if (accept)    state_next = S_B;
                S_B:     if (accept)    state_next = S_C;
                S_C:     if (accept)    state_next = S_SUM;
                S_SUM:                  state_next = S_OUT;
                S_OUT:   if (out_ready) state_next = S_A;
                default:                state_next = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_A;
            add_x    <= '0;
            add_y    <= '0;
            add_z    <= '0;
            out_data <= '0;
        end else begin
            state <= state_next;
            if (clr) begin
                // Abort keeps the last result word; only its valid flag goes away via the state.
                add_x <= '0;
                add_y <= '0;
                add_z <= '0;
            end else begin
                if (accept && state == S_A) add_x <= in_data;
                if (accept && state == S_B) add_y <= in_data;
                if (accept && state == S_C) add_z <= in_data;
                if (state == S_SUM)         out_data <= {add_cout, add_s};
            end
        end
    end

endmodule

// File: tb/tb_operand_seq3.sv
// Directed bench for operand_seq3 with a behavioural adder and a scoreboard of expected triples.
module tb_operand_seq3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] add_x;
    logic [3:0] add_y;
    logic [3:0] add_z;
    logic [4:0] add_s;
    logic       add_cout;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
        logic [5:0] sum;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] cur_ops[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = 6'(add_x) + 6'(add_y) + 6'(add_z);

    operand_seq3 #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_z     (add_z),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand until it is taken; the triple is scored when the third one lands.
    task automatic send_op(input logic [3:0] v);
        bit   done = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 20 && !done; i++) begin
            done = (in_ready === 1'b1) && !clr;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            chk("send_timeout", 8'd0, 8'd1);
        end else begin
            cur_ops.push_back(v);
            if (cur_ops.size() == 3) begin
                e.x   = cur_ops[0];
                e.y   = cur_ops[1];
                e.z   = cur_ops[2];
                e.sum = 6'(cur_ops[0]) + 6'(cur_ops[1]) + 6'(cur_ops[2]);
                exp_q.push_back(e);
                cur_ops.delete();
            end
        end
    endtask

    task automatic get_result(input string tag, input bit take);
        bit   seen = 0;
        exp_t e;
        out_ready = take;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid === 1'b1) seen = 1;
            else step();
        end
        if (!seen || exp_q.size() == 0) begin
            chk({tag, "_timeout"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 8'(out_data), 8'(e.sum));
            chk({tag, "_x"}, 8'(add_x), 8'(e.x));
            chk({tag, "_y"}, 8'(add_y), 8'(e.y));
            chk({tag, "_z"}, 8'(add_z), 8'(e.z));
            if (take) begin
                step();
                out_ready = 1'b0;
                chk({tag, "_rdy_after"}, 8'(in_ready), 8'd1);
                chk({tag, "_vld_after"}, 8'(out_valid), 8'd0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_out_data", 8'(out_data), 8'd0);
        chk("rst_add_x", 8'(add_x), 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 8'(in_ready), 8'd1);

        // Basic 3+5+7 with exact latency
        out_ready = 1'b1;
        send_op(4'd3);
        send_op(4'd5);
        send_op(4'd7);
        chk("basic_sum_state", 8'(out_valid), 8'd0);
        chk("basic_sum_rdy", 8'(in_ready), 8'd0);
        step();
        chk("basic_latency", 8'(out_valid), 8'd1);
        get_result("basic", 1'b1);

        // Max operands, carry out set
        send_op(4'd15);
        send_op(4'd15);
        send_op(4'd15);
        get_result("max", 1'b1);

        // Backpressure with a stray operand that must be ignored
        send_op(4'd1);
        send_op(4'd2);
        send_op(4'd4);
        get_result("bp_hold0", 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            in_data  = 4'd9;
            chk("bp_in_ready", 8'(in_ready), 8'd0);
            step();
            chk("bp_valid", 8'(out_valid), 8'd1);
            chk("bp_data", 8'(out_data), 8'd7);
            chk("bp_x", 8'(add_x), 8'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_rdy", 8'(in_ready), 8'd1);
        chk("bp_release_vld", 8'(out_valid), 8'd0);
        chk("bp_z_kept", 8'(add_z), 8'd4);
        send_op(4'd0);
        send_op(4'd0);
        send_op(4'd1);
        get_result("bp_next", 1'b1);

        // Abort after two operands; the operand offered with clr is dropped
        send_op(4'd8);
        send_op(4'd8);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd8;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        cur_ops.delete();
        chk("clr_add_x", 8'(add_x), 8'd0);
        chk("clr_add_y", 8'(add_y), 8'd0);
        chk("clr_add_z", 8'(add_z), 8'd0);
        chk("clr_in_ready", 8'(in_ready), 8'd1);
        chk("clr_out_valid", 8'(out_valid), 8'd0);
        chk("clr_out_kept", 8'(out_data), 8'd1);
        send_op(4'd1);
        send_op(4'd2);
        send_op(4'd3);
        get_result("clr_next", 1'b1);

        // Reset while holding a result
        send_op(4'd5);
        send_op(4'd5);
        send_op(4'd5);
        get_result("rh_hold", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rh_rdy_in_rst", 8'(in_ready), 8'd0);
        chk("rh_vld_in_rst", 8'(out_valid), 8'd0);
        step();
        chk("rh_out_data", 8'(out_data), 8'd0);
        chk("rh_vld_after_edge", 8'(out_valid), 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rh_rdy_release", 8'(in_ready), 8'd1);
        send_op(4'd4);
        send_op(4'd4);
        send_op(4'd4);
        get_result("rh_next", 1'b1);

        // Random gaps between operands
        begin
            logic [3:0] ops[3];
            ops[0] = 4'd10;
            ops[1] = 4'd0;
            ops[2] = 4'd5;
            for (int k = 0; k < 3; k++) begin
                int unsigned gap;
                gap = $urandom_range(0, 4);
                for (int unsigned g = 0; g < gap; g++) step();
                send_op(ops[k]);
            end
        end
        get_result("gaps", 1'b1);

        chk("sb_empty", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
